reg_write_arbiter: RTL and testbench
====================================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter N, default 8: data width of the shared register.
REQ-002 Parameter R, default 4: number of requesters, range 2..16.
REQ-003 Parameter HOLD, default 2: idle cycles enforced after each load, range 0..15.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-006 req  input  R  per-requester write request, level-sensitive.
REQ-007 din  input  R*N  flattened write data; requester i owns bits [i*N +: N].
REQ-008 ack  output  R  one-hot pulse; the granted requester's data is loaded this cycle.
REQ-009 grant_id  output  $clog2(R)  index of the current or most recent grantee.
REQ-010 busy  output  1  high whenever the state is not IDLE.
REQ-011 q  output  N  shared register contents.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, LOAD and HOLD.
REQ-013 IDLE, any req high: select the first requester at or after rotating pointer ptr (modulo R), register its index in grant_id, go to LOAD.
REQ-014 IDLE, no req high: remain in IDLE; q, ptr and grant_id unchanged.
REQ-015 LOAD, req[grant_id] still high: assert ack[grant_id] for exactly this one cycle; q <= din slice of grant_id at the closing edge; ptr <= (grant_id+1) mod R.
REQ-016 LOAD, req[grant_id] low (withdrawn): abort; no ack, q and ptr unchanged, next state IDLE.
REQ-017 Latency: req first sampled high in IDLE at cycle t -> ack high in cycle t+1 -> new q visible from cycle t+2.
REQ-018 After a completed LOAD, go to HOLD for exactly HOLD cycles, then IDLE; with HOLD=0 go directly to IDLE.
REQ-019 Requests arriving during LOAD or HOLD SHALL be ignored until the next IDLE cycle; nothing is queued.
REQ-020 A requester that holds req high after its ack SHALL be re-arbitrated behind all other active requesters.
REQ-021 At most one ack bit SHALL be high in any cycle; ack SHALL be 0 outside LOAD.
REQ-022 ptr SHALL wrap from R-1 to 0.
REQ-023 Requesters SHALL keep din stable from req rising until ack; the block samples din only in the LOAD cycle.

Reset
REQ-024 reset low at a rising edge: state IDLE, q=0, ptr=0, grant_id=0, ack=0, busy=0, at that edge.
REQ-025 Reset asserted in LOAD or HOLD SHALL abort the operation; no load occurs and no ack is issued in that cycle.
REQ-026 req SHALL be ignored while reset is low.

Configuration
REQ-027 Macro REG_ARB_STATS_EN defined: add output grant_count [15:0], reset to 0, incremented on each completed LOAD, saturating at 16'hFFFF.
REQ-028 Macro REG_ARB_STATS_EN undefined: port grant_count and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-029 Package reg_arb_pkg SHALL hold the state enum type (IDLE, LOAD, HOLD) and the default parameter constants.
REQ-030 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs req, ptr; outputs valid, idx).

Verification
REQ-031 Reset, then req=4'b0001 with din0=8'hA5 -> ack=4'b0001 one cycle later; q=8'hA5 from the following cycle; busy high for 1+HOLD cycles.
REQ-032 req=4'b1111 held high, HOLD=2 -> grants in order 0,1,2,3,0; acks spaced 4 cycles apart.
REQ-033 ptr=3, req=4'b1001 -> grant 3, then grant 0 (wrap-around).
REQ-034 req[2] dropped during LOAD -> no ack, q unchanged, IDLE next cycle, next grant still starts at ptr.
REQ-035 reset low during HOLD after loading 8'h3C -> q=0, busy=0 next cycle; the first grant after reset goes to requester 0.
REQ-036 With REG_ARB_STATS_EN defined, 5 completed loads and 1 aborted load -> grant_count=5.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// ============================================================================
// Module      : reg_arb_pkg
// Description : Shared types and default constants for reg_write_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_arb_pkg;

  // Default configuration constants for the arbiter.
  localparam int DEF_N    = 8;
  localparam int DEF_R    = 4;
  localparam int DEF_HOLD = 2;

  // Arbiter states: IDLE, LOAD and HOLD. The S_ prefix keeps the HOLD state
  // distinct from the HOLD parameter of the top module.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_HOLD = 2'd2
  } state_t;

endpackage : reg_arb_pkg

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin selector. Returns the first active
//               request at or after ptr, wrapping modulo R.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter  int R  = 4,
  localparam int IW = $clog2(R)
) (
  input  logic [R-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [2*R-1:0] w_dbl;
  logic [R-1:0]   w_rot;
  logic [IW-1:0]  w_off;
  logic [IW:0]    w_sum;

  // Rotate so bit 0 corresponds to the requester at ptr.
  assign w_dbl = {req, req} >> ptr;
  assign w_rot = w_dbl[R-1:0];

  // Find the lowest set bit of the rotated vector (closest to ptr).
  always_comb begin
    w_off = '0;
    for (int k = R - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = IW'(k);
      end
    end
  end

  // Translate the rotated offset back into an absolute requester index.
  assign w_sum = {1'b0, ptr} + {1'b0, w_off};
  assign idx   = (w_sum >= (IW+1)'(R)) ? IW'(w_sum - (IW+1)'(R)) : w_sum[IW-1:0];
  assign valid = |req;

endmodule : rr_pick

`default_nettype wire

// File: rtl/reg_write_arbiter.sv
// ============================================================================
// Module      : reg_write_arbiter
// Description : Round-robin arbiter granting R requesters write access to a
//               shared N-bit register, with a HOLD-cycle quiet period after
//               every load.
//               Optional macro REG_ARB_STATS_EN adds the grant_count output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter  int N    = DEF_N,
  parameter  int R    = DEF_R,
  parameter  int HOLD = DEF_HOLD,
  localparam int IW   = $clog2(R)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [R-1:0]    req,
  input  logic [R*N-1:0]  din,
  output logic [R-1:0]    ack,
  output logic [IW-1:0]   grant_id,
  output logic            busy,
  output logic [N-1:0]    q
`ifdef REG_ARB_STATS_EN
  ,
  output logic [15:0]     grant_count
`endif
);

  localparam logic [3:0] c_HOLD_LAST = 4'((HOLD == 0) ? 0 : HOLD - 1);

  state_t        r_state;
  state_t        w_next_state;
  logic [N-1:0]  r_q;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_gid;
  logic [3:0]    r_hold_cnt;
  logic          w_pick_valid;
  logic [IW-1:0] w_pick_idx;
  logic          w_load;
  logic [IW-1:0] w_ptr_next;

  rr_pick #(
    .R (R)
  ) u_rr_pick (
    .req   (req),
    .ptr   (r_ptr),
    .valid (w_pick_valid),
    .idx   (w_pick_idx)
  );

  // Pointer moves to the slot just after the grantee, wrapping at R-1.
  assign w_ptr_next = (r_gid == IW'(R - 1)) ? '0 : r_gid + IW'(1);

  // Next-state logic; a load completes only if the grantee still requests.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pick_valid) begin
          w_next_state = S_LOAD;
        end
      end
      S_LOAD: begin
        if (req[r_gid]) begin
          w_load       = reset;
          w_next_state = (HOLD == 0) ? S_IDLE : S_HOLD;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_HOLD: begin
        if (r_hold_cnt == 4'd0) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Datapath: grant capture, register load, pointer advance, hold countdown.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q        <= '0;
      r_ptr      <= '0;
      r_gid      <= '0;
      r_hold_cnt <= '0;
    end else begin
      if (r_state == S_IDLE && w_pick_valid) begin
        r_gid <= w_pick_idx;
      end
      if (w_load) begin
        r_q        <= din[int'(r_gid)*N +: N];
        r_ptr      <= w_ptr_next;
        r_hold_cnt <= c_HOLD_LAST;
      end else if (r_state == S_HOLD && r_hold_cnt != 4'd0) begin
        r_hold_cnt <= r_hold_cnt - 4'd1;
      end
    end
  end

  // One-hot acknowledge, only in the cycle a load actually completes.
  always_comb begin
    ack = '0;
    if (w_load) begin
      ack[r_gid] = 1'b1;
    end
  end

  assign grant_id = r_gid;
  assign busy     = (r_state != S_IDLE);
  assign q        = r_q;

`ifdef REG_ARB_STATS_EN
  logic [15:0] r_grant_count;

  // Saturating count of completed loads.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_grant_count <= '0;
    end else if (w_load && r_grant_count != 16'hFFFF) begin
      r_grant_count <= r_grant_count + 16'd1;
    end
  end

  assign grant_count = r_grant_count;
`endif

endmodule : reg_write_arbiter

`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
// ============================================================================
// Module      : tb_reg_write_arbiter
// Description : Self-checking bench for reg_write_arbiter (N=8, R=4, HOLD=2).
//               Exercises grant_count when REG_ARB_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_write_arbiter;

  localparam int N    = 8;
  localparam int R    = 4;
  localparam int HOLD = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [R-1:0]   req;
  logic [R*N-1:0] din;
  logic [R-1:0]   ack;
  logic [1:0]     grant_id;
  logic           busy;
  logic [N-1:0]   q;
`ifdef REG_ARB_STATS_EN
  logic [15:0]    grant_count;
`endif

  always #5 clk = ~clk;

  reg_write_arbiter #(.N(N), .R(R), .HOLD(HOLD)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .din      (din),
    .ack      (ack),
    .grant_id (grant_id),
    .busy     (busy),
    .q        (q)
`ifdef REG_ARB_STATS_EN
    ,
    .grant_count (grant_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: pending grant, remaining quiet cycles, register value.
  int           m_ptr, m_gid, m_hold, m_cnt;
  bit           m_pend;
  logic [N-1:0] m_q;

  // Values sampled / predicted in the most recent step.
  logic [R-1:0] a_ack, e_ack;
  logic         a_busy, e_busy;
  logic [1:0]   a_gid, e_gid;
  logic [N-1:0] a_q, e_q;

  function automatic logic [R*N-1:0] put(input int i, input logic [N-1:0] v);
    logic [R*N-1:0] d;
    d = $urandom();
    d[i*N +: N] = v;
    return d;
  endfunction

  function automatic int onehot_idx(input logic [R-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < R; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Drive one cycle of inputs, sample outputs, then advance the model.
  task automatic step(input logic [R-1:0] rq, input logic rs, input logic [R*N-1:0] dn);
    @(negedge clk);
    req = rq; reset = rs; din = dn;
    #1;
    e_ack  = (m_pend && rs && rq[m_gid]) ? (R'(1) << m_gid) : '0;
    e_busy = m_pend || (m_hold > 0);
    e_gid  = 2'(m_gid);
    e_q    = m_q;
    a_ack = ack; a_busy = busy; a_gid = grant_id; a_q = q;
    @(posedge clk);
    if (!rs) begin
      m_q = '0; m_ptr = 0; m_gid = 0; m_pend = 0; m_hold = 0; m_cnt = 0;
    end else if (m_pend) begin
      m_pend = 0;
      if (rq[m_gid]) begin
        m_q   = dn[m_gid*N +: N];
        m_ptr = (m_gid + 1) % R;
        m_hold = HOLD;
        if (m_cnt < 65535) m_cnt++;
      end
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (rq != '0) begin
      for (int k = 0; k < R; k++) begin
        if (rq[(m_ptr + k) % R]) begin
          m_gid  = (m_ptr + k) % R;
          m_pend = 1;
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    step(4'hF, 1'b0, $urandom());
    for (int i = 0; i < 3; i++) begin
      step(4'($urandom_range(0, 15)), 1'b0, $urandom());
      checks++;
      if ({a_ack, a_busy, a_gid, a_q} !== {4'b0, 1'b0, 2'd0, 8'h00}) begin
        errors++;
        $display("FAIL reset_state: ack=%b busy=%b gid=%0d q=%h, want all zero", a_ack, a_busy, a_gid, a_q);
      end
    end
  endtask

  task automatic test_single();
    logic [R*N-1:0] d;
    int busy_cnt;
    step('0, 1'b0, '0);
    d = put(0, 8'hA5);
    step(4'b0001, 1'b1, d);
    checks++;
    if (a_ack !== 4'b0000) begin errors++; $display("FAIL single_ack_t: got %b want 0000", a_ack); end
    step(4'b0001, 1'b1, d);
    busy_cnt = int'(a_busy);
    checks++;
    if (a_ack !== 4'b0001) begin errors++; $display("FAIL single_ack_t1: got %b want 0001", a_ack); end
    for (int i = 0; i < 5; i++) begin
      step('0, 1'b1, $urandom());
      busy_cnt += int'(a_busy);
      if (i == 0) begin
        checks++;
        if (a_q !== 8'hA5) begin errors++; $display("FAIL single_q_t2: got %h want a5", a_q); end
      end
    end
    checks++;
    if (busy_cnt != 1 + HOLD) begin errors++; $display("FAIL single_busy_len: got %0d want %0d", busy_cnt, 1 + HOLD); end
  endtask

  task automatic test_round_robin();
    int ids[$];
    int cyc[$];
    step('0, 1'b0, '0);
    for (int c = 0; c < 19; c++) begin
      step(4'hF, 1'b1, $urandom());
      checks++;
      if (a_ack !== e_ack) begin errors++; $display("FAIL rr_ack: cycle %0d got %b want %b", c, a_ack, e_ack); end
      if (a_ack != '0) begin ids.push_back(onehot_idx(a_ack)); cyc.push_back(c); end
    end
    checks++;
    if (ids.size() < 5) begin
      errors++; $display("FAIL rr_count: got %0d acks want 5", ids.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (ids[i] != i % R) begin errors++; $display("FAIL rr_order: ack %0d got id %0d want %0d", i, ids[i], i % R); end
      end
      for (int i = 1; i < 5; i++) begin
        checks++;
        if (cyc[i] - cyc[i-1] != 2 + HOLD) begin errors++; $display("FAIL rr_spacing: gap %0d got %0d want %0d", i, cyc[i] - cyc[i-1], 2 + HOLD); end
      end
    end
  endtask

  task automatic test_wrap();
    logic [R-1:0] acks[$];
    step('0, 1'b0, '0);
    step(4'b0100, 1'b1, put(2, 8'h22));
    step(4'b0100, 1'b1, put(2, 8'h22));
    step('0, 1'b1, $urandom());
    step('0, 1'b1, $urandom());
    for (int c = 0; c < 9; c++) begin
      step(4'b1001, 1'b1, $urandom());
      if (a_ack != '0) acks.push_back(a_ack);
    end
    checks++;
    if (acks.size() < 2) begin
      errors++; $display("FAIL wrap_count: got %0d acks want 2", acks.size());
    end else begin
      checks++;
      if (acks[0] !== 4'b1000) begin errors++; $display("FAIL wrap_first: got %b want 1000", acks[0]); end
      checks++;
      if (acks[1] !== 4'b0001) begin errors++; $display("FAIL wrap_second: got %b want 0001", acks[1]); end
    end
  endtask

  task automatic test_abort();
    logic [R*N-1:0] d;
    step('0, 1'b0, '0);
    d = put(1, 8'h5A);
    step(4'b0010, 1'b1, d);
    step(4'b0010, 1'b1, d);
    step('0, 1'b1, $urandom());
    step('0, 1'b1, $urandom());
    d = put(2, 8'h11);
    step(4'b0100, 1'b1, d);
    step(4'b0000, 1'b1, d);
    checks++;
    if (a_ack !== 4'b0000 || a_busy !== 1'b1) begin
      errors++; $display("FAIL abort_load: ack=%b busy=%b want ack=0000 busy=1", a_ack, a_busy);
    end
    step(4'hF, 1'b1, $urandom());
    checks++;
    if (a_busy !== 1'b0 || a_q !== 8'h5A) begin
      errors++; $display("FAIL abort_idle: busy=%b q=%h want busy=0 q=5a", a_busy, a_q);
    end
    step(4'hF, 1'b1, $urandom());
    checks++;
    if (a_ack !== 4'b0100) begin errors++; $display("FAIL abort_next_grant: got %b want 0100", a_ack); end
  endtask

  task automatic test_reset_in_hold();
    logic [R*N-1:0] d;
    step('0, 1'b0, '0);
    d = put(1, 8'h3C);
    step(4'b0010, 1'b1, d);
    step(4'b0010, 1'b1, d);
    step('0, 1'b1, $urandom());
    checks++;
    if (a_q !== 8'h3C || a_busy !== 1'b1) begin errors++; $display("FAIL hold_loaded: q=%h busy=%b want 3c/1", a_q, a_busy); end
    step('0, 1'b0, $urandom());
    step(4'hF, 1'b1, $urandom());
    checks++;
    if (a_q !== 8'h00 || a_busy !== 1'b0) begin errors++; $display("FAIL hold_reset: q=%h busy=%b want 00/0", a_q, a_busy); end
    step(4'hF, 1'b1, $urandom());
    checks++;
    if (a_ack !== 4'b0001 || a_gid !== 2'd0) begin errors++; $display("FAIL hold_first_grant: ack=%b gid=%0d want 0001/0", a_ack, a_gid); end
    // Reset during LOAD: no ack in that cycle and no load afterwards.
    step('0, 1'b0, '0);
    d = put(0, 8'h77);
    step(4'b0001, 1'b1, d);
    step(4'b0001, 1'b0, d);
    checks++;
    if (a_ack !== 4'b0000) begin errors++; $display("FAIL load_reset_ack: got %b want 0000", a_ack); end
    step('0, 1'b1, $urandom());
    checks++;
    if (a_q !== 8'h00 || a_busy !== 1'b0) begin errors++; $display("FAIL load_reset_q: q=%h busy=%b want 00/0", a_q, a_busy); end
  endtask

  task automatic test_random();
    logic [R-1:0] rq;
    logic         rs;
    step('0, 1'b0, '0);
    for (int c = 0; c < 400; c++) begin
      rq = 4'($urandom_range(0, 15));
      rs = ($urandom_range(0, 99) >= 3);
      step(rq, rs, $urandom());
      checks++;
      if ({a_ack, a_busy, a_gid, a_q} !== {e_ack, e_busy, e_gid, e_q}) begin
        errors++;
        $display("FAIL random_cycle %0d: ack=%b busy=%b gid=%0d q=%h, want ack=%b busy=%b gid=%0d q=%h",
                 c, a_ack, a_busy, a_gid, a_q, e_ack, e_busy, e_gid, e_q);
      end
    end
  endtask

`ifdef REG_ARB_STATS_EN
  task automatic test_stats();
    step('0, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      step(4'b0001, 1'b1, $urandom());
      step(4'b0001, 1'b1, $urandom());
      step('0, 1'b1, $urandom());
      step('0, 1'b1, $urandom());
    end
    step(4'b0010, 1'b1, $urandom());
    step(4'b0000, 1'b1, $urandom());
    step('0, 1'b1, $urandom());
    checks++;
    if (grant_count !== 16'd5) begin errors++; $display("FAIL stats_count: got %0d want 5", grant_count); end
  endtask
`endif

  initial begin
    reset = 1'b0;
    req   = '0;
    din   = '0;
    m_ptr = 0; m_gid = 0; m_hold = 0; m_cnt = 0; m_pend = 0; m_q = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_abort();
    test_reset_in_hold();
    test_random();
`ifdef REG_ARB_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_reg_write_arbiter

`default_nettype wire
